// File: rtl/s_protocol_adapter_ingress.sv
// s_protocol_adapter_ingress
//
// Ingress packet adapter between the open-nic-shell AXI-stream and MoSAIC.
// Each accepted beat has its byte lanes (and TKEEP bits) reversed. All-zero-TKEEP filler
// beats without TLAST are discarded. Packets longer than MAX_BEATS are cut short: the
// MAX_BEATS-th beat is marked last and the rest of the packet is dropped. The result goes
// through an output register plus one skid register, so both sides sustain one beat per
// cycle under backpressure.
//
// Ports:
//   clk_line          line clock, all logic on the rising edge
//   rst               asynchronous active-high reset
//   stream_in_*       AXI-stream from the shell (TREADY is registered)
//   stream_out_*      AXI-stream to MoSAIC (TVALID/TDATA/TKEEP/TLAST are registered)
//   pkt_trunc         one-cycle pulse after a packet has been truncated
//   pkt_count         number of packets emitted (TLAST handshakes on the output), wraps

module s_protocol_adapter_ingress #(
  parameter int BW        = 32,
  parameter int BWB       = BW / 8,
  parameter int MAX_BEATS = 375
) (
  input  logic           clk_line,
  input  logic           rst,
  input  logic [BW-1:0]  stream_in_TDATA,
  input  logic [BWB-1:0] stream_in_TKEEP,
  input  logic           stream_in_TLAST,
  input  logic           stream_in_TVALID,
  output logic           stream_in_TREADY,
  output logic [BW-1:0]  stream_out_TDATA,
  output logic [BWB-1:0] stream_out_TKEEP,
  output logic           stream_out_TLAST,
  output logic           stream_out_TVALID,
  input  logic           stream_out_TREADY,
  output logic           pkt_trunc,
  output logic [31:0]    pkt_count
);

  localparam int CW = $clog2(MAX_BEATS + 1);

  typedef enum logic {
    StPass,
    StDrop
  } state_e;

  // Packet-length FSM
  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            trunc_q, trunc_d;

  // Output register and skid register
  logic            out_valid_q, out_valid_d;
  logic [BW-1:0]   out_data_q, out_data_d;
  logic [BWB-1:0]  out_keep_q, out_keep_d;
  logic            out_last_q, out_last_d;
  logic            skid_valid_q, skid_valid_d;
  logic [BW-1:0]   skid_data_q, skid_data_d;
  logic [BWB-1:0]  skid_keep_q, skid_keep_d;
  logic            skid_last_q, skid_last_d;

  logic            in_ready_q, in_ready_d;
  logic [31:0]     pkt_count_q, pkt_count_d;

  logic            accept;
  logic            filler;
  logic            emit;
  logic            wr;
  logic            wr_last;
  logic [BW-1:0]   sw_data;
  logic [BWB-1:0]  sw_keep;

  assign accept = stream_in_TVALID & in_ready_q;
  assign filler = (stream_in_TKEEP == '0) & ~stream_in_TLAST;
  assign emit   = out_valid_q & stream_out_TREADY;

  // Byte-lane reversal: output lane i takes input lane BWB-1-i.
  always_comb begin
    sw_data = '0;
    sw_keep = '0;
    for (int i = 0; i < BWB; i++) begin
      sw_data[8*i +: 8] = stream_in_TDATA[8*(BWB-1-i) +: 8];
      sw_keep[i]        = stream_in_TKEEP[BWB-1-i];
    end
  end

  // Decide whether an accepted beat is written into the buffer and with which TLAST.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    trunc_d = 1'b0;
    wr      = 1'b0;
    wr_last = stream_in_TLAST;
    if (accept) begin
      case (state_q)
        StPass: begin
          if (!filler) begin
            wr = 1'b1;
            if (stream_in_TLAST) begin
              cnt_d = '0;
            end else if (cnt_q == CW'(MAX_BEATS - 1)) begin
              // Length limit reached without TLAST: close the packet here, drop the rest.
              wr_last = 1'b1;
              cnt_d   = '0;
              trunc_d = 1'b1;
              state_d = StDrop;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        StDrop: begin
          if (stream_in_TLAST) begin
            state_d = StPass;
          end
        end
        default: begin
          state_d = StPass;
        end
      endcase
    end
  end

  // Two-entry buffer. The skid only fills when a beat is written while the output register
  // holds a beat that is not leaving this cycle.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_keep_d   = out_keep_q;
    out_last_d   = out_last_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_keep_d  = skid_keep_q;
    skid_last_d  = skid_last_q;
    if (!out_valid_q || emit) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        out_keep_d   = skid_keep_q;
        out_last_d   = skid_last_q;
        skid_valid_d = wr;
        if (wr) begin
          skid_data_d = sw_data;
          skid_keep_d = sw_keep;
          skid_last_d = wr_last;
        end
      end else begin
        out_valid_d = wr;
        if (wr) begin
          out_data_d = sw_data;
          out_keep_d = sw_keep;
          out_last_d = wr_last;
        end
      end
    end else if (wr) begin
      skid_valid_d = 1'b1;
      skid_data_d  = sw_data;
      skid_keep_d  = sw_keep;
      skid_last_d  = wr_last;
    end
  end

  // Ready is registered from the next skid state, so it never depends on the output side
  // combinationally.
  assign in_ready_d = ~skid_valid_d;

  always_comb begin
    pkt_count_d = pkt_count_q;
    if (emit && out_last_q) begin
      pkt_count_d = pkt_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk_line or posedge rst) begin
    if (rst) begin
      state_q      <= StPass;
      cnt_q        <= '0;
      trunc_q      <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_keep_q   <= '0;
      out_last_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_keep_q  <= '0;
      skid_last_q  <= 1'b0;
      in_ready_q   <= 1'b0;
      pkt_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      trunc_q      <= trunc_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_keep_q   <= out_keep_d;
      out_last_q   <= out_last_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_keep_q  <= skid_keep_d;
      skid_last_q  <= skid_last_d;
      in_ready_q   <= in_ready_d;
      pkt_count_q  <= pkt_count_d;
    end
  end

  assign stream_in_TREADY  = in_ready_q;
  assign stream_out_TVALID = out_valid_q;
  assign stream_out_TDATA  = out_data_q;
  assign stream_out_TKEEP  = out_keep_q;
  assign stream_out_TLAST  = out_last_q;
  assign pkt_trunc         = trunc_q;
  assign pkt_count         = pkt_count_q;

endmodule

// File: tb/tb_s_protocol_adapter_ingress.sv
// Testbench for s_protocol_adapter_ingress (BW=32, MAX_BEATS=4).
// Stimulus pushes expected output beats into a queue; a monitor pops and compares them
// whenever the DUT emits a beat.

module tb_s_protocol_adapter_ingress;

  localparam int BW   = 32;
  localparam int BWB  = 4;
  localparam int MAXB = 4;

  logic           clk_line = 1'b0;
  logic           rst = 1'b1;
  logic [BW-1:0]  in_data = '0;
  logic [BWB-1:0] in_keep = '0;
  logic           in_last = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [BW-1:0]  out_data;
  logic [BWB-1:0] out_keep;
  logic           out_last;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic           pkt_trunc;
  logic [31:0]    pkt_count;

  s_protocol_adapter_ingress #(
    .BW        (BW),
    .BWB       (BWB),
    .MAX_BEATS (MAXB)
  ) dut (
    .clk_line          (clk_line),
    .rst               (rst),
    .stream_in_TDATA   (in_data),
    .stream_in_TKEEP   (in_keep),
    .stream_in_TLAST   (in_last),
    .stream_in_TVALID  (in_valid),
    .stream_in_TREADY  (in_ready),
    .stream_out_TDATA  (out_data),
    .stream_out_TKEEP  (out_keep),
    .stream_out_TLAST  (out_last),
    .stream_out_TVALID (out_valid),
    .stream_out_TREADY (out_ready),
    .pkt_trunc         (pkt_trunc),
    .pkt_count         (pkt_count)
  );

  always #5 clk_line = ~clk_line;

  typedef struct packed {
    logic [BW-1:0]  d;
    logic [BWB-1:0] k;
    logic           l;
  } beat_t;

  beat_t exp_q[$];
  int    emit_cyc_q[$];
  int    cyc = 0;
  int    n_checks = 0;
  int    n_pass = 0;
  int    stalls = 0;
  int    acc_cyc = 0;
  int    trunc_cycles = 0;
  int    rdy_mode = 0;  // 0: ready high, 1: toggle every cycle, 2: ready low

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [BW-1:0] swapd(input logic [BW-1:0] d);
    logic [BW-1:0] r;
    for (int i = 0; i < BWB; i++) r[8*i +: 8] = d[8*(BWB-1-i) +: 8];
    return r;
  endfunction

  function automatic logic [BWB-1:0] swapk(input logic [BWB-1:0] k);
    logic [BWB-1:0] r;
    for (int i = 0; i < BWB; i++) r[i] = k[BWB-1-i];
    return r;
  endfunction

  initial forever begin
    @(posedge clk_line);
    cyc++;
  end

  initial forever begin
    @(posedge clk_line);
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor: scoreboard compare on every emit, plus hold-stability under backpressure.
  initial begin
    logic  hold;
    beat_t prev;
    beat_t e;
    hold = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk_line);
      if (rst) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          chk("hold_valid", 64'(out_valid), 64'd1);
          chk("hold_beat", 64'({out_data, out_keep, out_last}), 64'(prev));
        end
        if (out_valid && out_ready) begin
          emit_cyc_q.push_back(cyc);
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_beat: got %0h, expected no beat (cycle %0d)",
                     {out_data, out_keep, out_last}, cyc);
          end else begin
            e = exp_q.pop_front();
            chk("out_beat", 64'({out_data, out_keep, out_last}), 64'(e));
          end
        end
        hold = out_valid && !out_ready;
        prev = {out_data, out_keep, out_last};
        if (pkt_trunc) trunc_cycles++;
      end
    end
  end

  // Send one beat with an explicit expected output (or none if ex=0).
  task automatic sendx(input logic [BW-1:0] d, input logic [BWB-1:0] k, input logic l,
                       input bit ex, input logic [BW-1:0] ed, input logic [BWB-1:0] ek,
                       input logic el, input int idle);
    bit done;
    in_valid = 1'b0;
    repeat (idle) begin
      @(posedge clk_line);
      #1;
    end
    in_data  = d;
    in_keep  = k;
    in_last  = l;
    in_valid = 1'b1;
    done     = 1'b0;
    for (int w = 0; w < 100 && !done; w++) begin
      @(negedge clk_line);
      if (in_ready) begin
        if (ex) exp_q.push_back('{d: ed, k: ek, l: el});
        acc_cyc = cyc;
        @(posedge clk_line);
        #1;
        done = 1'b1;
      end else begin
        stalls++;
      end
    end
    in_valid = 1'b0;
    if (!done) begin
      n_checks++;
      $display("FAIL send_timeout: TREADY stayed 0, expected 1 within 100 cycles");
    end
  endtask

  task automatic send(input logic [BW-1:0] d, input logic [BWB-1:0] k, input logic l,
                      input bit ex, input logic el, input int idle);
    sendx(d, k, l, ex, swapd(d), swapk(k), el, idle);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) begin
      @(posedge clk_line);
      #1;
    end
    repeat (3) begin
      @(posedge clk_line);
      #1;
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    chk({tag, "_rst_tvalid"}, 64'(out_valid), 64'd0);
    chk({tag, "_rst_tready"}, 64'(in_ready), 64'd0);
    chk({tag, "_rst_out"}, 64'({out_data, out_keep, out_last, pkt_trunc}), 64'd0);
    chk({tag, "_rst_count"}, 64'(pkt_count), 64'd0);
    @(posedge clk_line);
    #1;
    rst = 1'b0;
    #1;
    chk({tag, "_rel_tready_lo"}, 64'(in_ready), 64'd0);
    @(posedge clk_line);
    #1;
    chk({tag, "_rel_tready_hi"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a0;
    int tr0;
    #2;

    // 1: byte swap, one-beat packet
    do_reset("t1");
    sendx(32'h11223344, 4'b0111, 1'b1, 1'b1, 32'h44332211, 4'b1110, 1'b1, 0);
    a0 = acc_cyc;
    drain();
    chk("t1_latency", 64'((emit_cyc_q.size() > 0) ? emit_cyc_q[$] - a0 : -1), 64'd1);
    chk("t1_pkt_count", 64'(pkt_count), 64'd1);

    // 2: truncation of a 6-beat packet at 4 beats, then an intact 2-beat packet
    do_reset("t2");
    tr0 = trunc_cycles;
    sendx(32'h00000001, 4'hF, 1'b0, 1'b1, 32'h01000000, 4'hF, 1'b0, 0);
    sendx(32'h00000002, 4'hF, 1'b0, 1'b1, 32'h02000000, 4'hF, 1'b0, 0);
    sendx(32'h00000003, 4'hF, 1'b0, 1'b1, 32'h03000000, 4'hF, 1'b0, 0);
    sendx(32'h00000004, 4'hF, 1'b0, 1'b1, 32'h04000000, 4'hF, 1'b1, 0);
    sendx(32'h00000005, 4'hF, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 0);
    sendx(32'h00000006, 4'hF, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 0);
    sendx(32'hAABBCCDD, 4'hF, 1'b0, 1'b1, 32'hDDCCBBAA, 4'hF, 1'b0, 0);
    sendx(32'h12345678, 4'b0011, 1'b1, 1'b1, 32'h78563412, 4'b1100, 1'b1, 0);
    drain();
    chk("t2_trunc_cycles", 64'(trunc_cycles - tr0), 64'd1);
    chk("t2_pkt_count", 64'(pkt_count), 64'd2);

    // 3: backpressure, 64 beats in 4-beat packets, random gaps, toggling ready
    do_reset("t3");
    rdy_mode = 1;
    for (int i = 0; i < 64; i++) begin
      send(32'hC0DE0000 + 32'(i) * 32'h00010203, 4'hF, 1'(i % 4 == 3), 1'b1,
           1'(i % 4 == 3), int'($urandom_range(0, 1)));
    end
    drain();
    rdy_mode = 0;
    repeat (2) begin
      @(posedge clk_line);
      #1;
    end
    chk("t3_pkt_count", 64'(pkt_count), 64'd16);

    // 4: full throughput, 100 beats
    do_reset("t4");
    stalls = 0;
    emit_cyc_q.delete();
    a0 = 0;
    for (int i = 0; i < 100; i++) begin
      send(32'h5A000000 + 32'(i) * 32'h01010101, 4'hF, 1'(i % 4 == 3), 1'b1,
           1'(i % 4 == 3), 0);
      if (i == 0) a0 = acc_cyc;
    end
    drain();
    chk("t4_beats", 64'(emit_cyc_q.size()), 64'd100);
    chk("t4_latency", 64'((emit_cyc_q.size() > 0) ? emit_cyc_q[0] - a0 : -1), 64'd1);
    chk("t4_span", 64'((emit_cyc_q.size() > 0) ? emit_cyc_q[$] - emit_cyc_q[0] : -1), 64'd99);
    chk("t4_stalls", 64'(stalls), 64'd0);
    chk("t4_pkt_count", 64'(pkt_count), 64'd25);

    // 5: filler beats
    do_reset("t5");
    sendx(32'hA1A2A3A4, 4'hF, 1'b0, 1'b1, 32'hA4A3A2A1, 4'hF, 1'b0, 0);
    sendx(32'h00000000, 4'h0, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 0);
    sendx(32'hB1B2B3B4, 4'hF, 1'b1, 1'b1, 32'hB4B3B2B1, 4'hF, 1'b1, 0);
    sendx(32'h00000000, 4'h0, 1'b1, 1'b1, 32'h00000000, 4'h0, 1'b1, 0);
    drain();
    chk("t5_pkt_count", 64'(pkt_count), 64'd2);

    // 6: reset in the middle of an 8-beat packet
    do_reset("t6");
    sendx(32'h01020304, 4'hF, 1'b0, 1'b1, 32'h04030201, 4'hF, 1'b0, 0);
    sendx(32'h05060708, 4'hF, 1'b0, 1'b1, 32'h08070605, 4'hF, 1'b0, 0);
    drain();
    rdy_mode = 2;
    repeat (2) begin
      @(posedge clk_line);
      #1;
    end
    sendx(32'h090A0B0C, 4'hF, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 0);
    @(posedge clk_line);
    #1;
    chk("t6_beat3_held", 64'(out_valid), 64'd1);
    rdy_mode = 0;
    do_reset("t6mid");
    exp_q.delete();
    sendx(32'hE1E2E3E4, 4'hF, 1'b0, 1'b1, 32'hE4E3E2E1, 4'hF, 1'b0, 0);
    sendx(32'hF1F2F3F4, 4'b1000, 1'b1, 1'b1, 32'hF4F3F2F1, 4'b0001, 1'b1, 0);
    drain();
    chk("t6_pkt_count", 64'(pkt_count), 64'd1);

    chk("trunc_total", 64'(trunc_cycles), 64'd1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
